// File: rtl/rangefinder_pkg.sv
// rangefinder_pkg: shared state encoding and default geometry for the rangefinder capture engine
package rangefinder_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int NUM_SAMPLES_DEF = 256;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
endpackage

// File: rtl/rangefinder_sample_writer_if.sv
// rangefinder_sample_writer_if: ADC sample stream in, sample RAM second write port out
interface rangefinder_sample_writer_if
    import rangefinder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    modport master (input smp_valid, smp_data, output ram_address, ram_chipselect, ram_write, ram_writedata);
    modport slave (output smp_valid, smp_data, input ram_address, ram_chipselect, ram_write, ram_writedata);
endinterface

// File: rtl/rangefinder_peak_track.sv
// rangefinder_peak_track: tracks the first strictly-largest sample of a capture and its address
module rangefinder_peak_track #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] peak_value,
    output logic [ADDR_W-1:0] peak_addr
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            peak_value <= '0;
            peak_addr  <= '0;
        end else if (clr) begin
            peak_value <= '0;
            peak_addr  <= '0;
        end else if (load && data > peak_value) begin
            peak_value <= data;
            peak_addr  <= addr;
        end
endmodule

// File: rtl/rangefinder_sample_writer.sv
// rangefinder_sample_writer: armed trigger-started capture of NUM_SAMPLES ADC samples into sample RAM.
// Optional peak tracking under RANGEFINDER_PEAK_TRACK_EN.
module rangefinder_sample_writer
    import rangefinder_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int NUM_SAMPLES  = NUM_SAMPLES_DEF,
    parameter int TRIG_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trigger,
    rangefinder_sample_writer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [ADDR_W:0]      count,
    output logic                 irq
`ifdef RANGEFINDER_PEAK_TRACK_EN
    ,
    output logic [DATA_W-1:0]    peak_value,
    output logic [ADDR_W-1:0]    peak_addr
`endif
);
    state_t          state;
    logic            trigger_q;
    logic [15:0]     tmo_cnt;
    logic            trig_edge;
    logic            arm_go;
    logic            accept;
    logic [ADDR_W:0] count_nxt;

    assign trig_edge = trigger & ~trigger_q;
    assign arm_go    = ~abort & arm & (state == IDLE || state == DONE);
    assign accept    = ~abort & bus.smp_valid & (state == CAPTURE);
    assign count_nxt = count + 1'b1;
    assign busy      = (state == ARMED) | (state == CAPTURE);

    // abort outranks everything; in ARMED the trigger edge outranks expiry
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state              <= IDLE;
            trigger_q          <= 1'b0;
            tmo_cnt            <= '0;
            done               <= 1'b0;
            timeout            <= 1'b0;
            count              <= '0;
            irq                <= 1'b0;
            bus.ram_address    <= '0;
            bus.ram_chipselect <= 1'b0;
            bus.ram_write      <= 1'b0;
            bus.ram_writedata  <= '0;
        end else begin
            trigger_q          <= trigger;
            irq                <= 1'b0;
            bus.ram_chipselect <= 1'b0;
            bus.ram_write      <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                done    <= 1'b0;
                timeout <= 1'b0;
            end else if (arm_go) begin
                state   <= ARMED;
                done    <= 1'b0;
                timeout <= 1'b0;
                count   <= '0;
                tmo_cnt <= 16'(TRIG_TIMEOUT);
            end else if (state == ARMED) begin
                if (trig_edge)
                    state <= CAPTURE;
                else if (tmo_cnt == 16'd1) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                    irq     <= 1'b1;
                    tmo_cnt <= '0;
                end else
                    tmo_cnt <= tmo_cnt - 1'b1;
            end else if (accept) begin
                bus.ram_chipselect <= 1'b1;
                bus.ram_write      <= 1'b1;
                bus.ram_address    <= count[ADDR_W-1:0];
                bus.ram_writedata  <= bus.smp_data;
                count              <= count_nxt;
                if (count_nxt == (ADDR_W+1)'(NUM_SAMPLES)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    irq   <= 1'b1;
                end
            end
        end

`ifdef RANGEFINDER_PEAK_TRACK_EN
    rangefinder_peak_track #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_peak (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (arm_go),
        .load       (accept),
        .addr       (count[ADDR_W-1:0]),
        .data       (bus.smp_data),
        .peak_value (peak_value),
        .peak_addr  (peak_addr)
    );
`endif
endmodule

// File: doc/rangefinder_sample_writer.md
# rangefinder_sample_writer

Capture engine that fills the 256×8 dual-port sample RAM from the ADC sample stream through the RAM's second write port, while the CPU reads results through the first port. Armed by the CPU, it waits for a laser-fire trigger edge, writes NUM_SAMPLES consecutive samples starting at address 0, then raises done/irq. A trigger timeout ends a capture attempt that never fires.

## Interface
Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, sample and RAM data width.
- NUM_SAMPLES, 256, samples per capture; 1..2^ADDR_W.
- TRIG_TIMEOUT, 65535, clk cycles to wait in ARMED; 1..65535.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle pulse from the CPU control register; starts a capture.
- abort  in  1  one-cycle pulse; cancels the current operation.
- trigger  in  1  laser-fire level, synchronous to clk; the rising edge starts sampling.
- smp_valid  in  1  sample strobe.
- smp_data  in  DATA_W  ADC sample.
- ram_address  out  ADDR_W  drives address2.
- ram_chipselect  out  1  drives chipselect2.
- ram_write  out  1  drives write2.
- ram_writedata  out  DATA_W  drives writedata2.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  sticky; set when the engine enters DONE, cleared by arm or abort.
- timeout  out  1  sticky; set when the trigger wait expired, cleared by arm or abort.
- count  out  ADDR_W+1  number of samples written in the current capture.
- irq  out  1  one-cycle pulse on entry to DONE.

## Operation
States:
- IDLE: waits for arm.
- ARMED
  - arm: clears done, timeout, count and the write address, and loads the timeout counter with TRIG_TIMEOUT.
  - A trigger rising edge (trigger & ~trigger_q) moves to CAPTURE.
  - The counter decrements every cycle; on reaching 0 the engine moves to DONE with timeout=1 and count=0.
  - If the edge and expiry occur in the same cycle, the trigger wins.
- CAPTURE
  - Each smp_valid cycle accepts smp_data, issues one RAM write at address count[ADDR_W-1:0], and increments count.
  - When the accepted sample makes count == NUM_SAMPLES, the engine moves to DONE.
- DONE: done=1. arm moves to ARMED, identical to arming from IDLE.

Edge and priority rules:
- trigger_q tracks trigger continuously, in every state. A trigger already high at arm does not count as an edge.
- smp_valid in the same cycle as the trigger edge is not captured; the first capturable sample is in the cycle after the edge.
- arm while in ARMED or CAPTURE is ignored.
- abort in any state returns to IDLE and clears done and timeout. No irq is issued. A sample accepted in the same cycle as abort is discarded and no write is issued. count holds its value.
- abort has priority over arm, trigger, timeout and smp_valid.

Reset and width rules:
- Reset mid-capture forces IDLE. The RAM keeps its partial contents.
- Reset values: every output is 0; state=IDLE; trigger_q=0.
- The address wraps naturally in ADDR_W bits. count never exceeds NUM_SAMPLES.

## Timing
- RAM port outputs are registered. ram_chipselect, ram_write, ram_address and ram_writedata are valid for exactly one cycle, one cycle after the accepted smp_valid.
- Back-to-back smp_valid produces back-to-back writes with no bubbles.
- Last sample:
  - Its write strobe, the entry to DONE, done=1 and irq=1 all appear in the same cycle, one cycle after acceptance.
  - count reaches NUM_SAMPLES in that same cycle.
- Trigger-to-CAPTURE latency: the edge is seen in cycle T and the state is CAPTURE at T+1.
- Timeout latency: DONE is entered TRIG_TIMEOUT+1 cycles after the arm pulse.

## Configuration
- RANGEFINDER_PEAK_TRACK_EN defined:
  - Adds output peak_value (DATA_W) and output peak_addr (ADDR_W).
  - Both reset to 0 and are cleared by arm.
  - peak_value updates when an accepted sample is strictly greater than the current peak; the first occurrence wins. peak_addr is that sample's write address.
  - Both update in the same cycle as the corresponding write.
- Undefined: the ports and logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package rangefinder_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DONE);
  - the ADDR_W and DATA_W defaults;
  - the NUM_SAMPLES default.
- Optional sub-module rangefinder_peak_track, instantiated only under RANGEFINDER_PEAK_TRACK_EN.
- The timeout counter and edge detector stay inline.

## Test plan
- Nominal capture, NUM_SAMPLES=256: arm, trigger edge, 256 consecutive smp_valid with data=address ^ 8'h5A -> writes at addresses 0..255 with matching data; done=1, irq pulses once, count=256.
- Gapped samples: smp_valid every third cycle -> one write strobe per sample, contiguous addresses, done after the 256th sample.
- Timeout with TRIG_TIMEOUT=10: arm, no trigger -> DONE 11 cycles after arm with timeout=1, count=0, irq pulse, no RAM writes.
- Abort after 100 samples, with smp_valid asserted in the abort cycle -> exactly 100 writes, IDLE, done=0, no irq. Re-arm then restarts at address 0.
- Trigger held high before arm -> no capture until trigger falls and rises again. A trigger edge and timeout expiry in the same cycle -> CAPTURE is entered.
- With RANGEFINDER_PEAK_TRACK_EN defined: samples 3, 200, 7, 200 -> peak_value=200, peak_addr=1.
